// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall bus encodings, address constants and FSM states for pipeline control
package pipe_ctrl_pkg;
    localparam int StallBusW = 6;
    localparam int InstAddrW = 32;
    localparam logic [StallBusW-1:0] StallNone = 6'b000000;
    localparam logic [StallBusW-1:0] StallId   = 6'b000111;
    localparam logic [StallBusW-1:0] StallEx   = 6'b001111;
    localparam logic [StallBusW-1:0] StallMem  = 6'b011111;
    localparam logic [StallBusW-1:0] StallAll  = 6'b111111;
    localparam logic [InstAddrW-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic                 NotStop   = 1'b0;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// pipe_ctrl_sat_counter: up-counter that sticks at LIMIT, with synchronous clear
module pipe_ctrl_sat_counter #(
    parameter int W = 8,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    // count up on inc until LIMIT; clear wins over inc
    always_ff @(posedge clk)
        q <= (rst || clr) ? '0 : (inc && q != LIMIT) ? q + 1'b1 : q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, exception flush/redirect, debug halt handshake and stall watchdog
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 1024,
    parameter int CNT_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        excp_valid_i,
    input  logic [31:0] excp_vector_i,
    input  logic        halt_req_i,
    input  logic        resume_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        halt_ack_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o
);
    state_t state, state_n;
    logic [CNT_W-1:0] wd_cnt;
    logic wd_inc, cyc_inc, any_req;

    assign any_req    = stallreq_id_i | stallreq_ex_i | stallreq_mem_i;
    assign halt_ack_o = (state == HALTED);

    // state register
    always_ff @(posedge clk)
        state <= rst ? RUN : state_n;

    // halt/resume sequencing; draining waits for a quiet pipeline with no exception
    always_comb begin
        state_n = state;
        case (state)
            RUN:     state_n = halt_req_i ? DRAIN : RUN;
            DRAIN:   state_n = !halt_req_i ? RUN : (!any_req && !excp_valid_i) ? HALTED : DRAIN;
            HALTED:  state_n = resume_i ? RUN : HALTED;
            default: state_n = RUN;
        endcase
    end

    // zero-latency stall bus and redirect; an exception overrides every stall request
    always_comb begin
        flush_o  = !rst && excp_valid_i && state != HALTED;
        new_pc_o = flush_o ? excp_vector_i : ZeroWord;
        stall_o  = (rst || flush_o) ? StallNone :
                   (state == HALTED) ? StallAll :
                   stallreq_mem_i ? StallMem :
                   stallreq_ex_i ? StallEx :
                   stallreq_id_i ? StallId : StallNone;
    end

    assign wd_inc  = (stall_o != StallNone) && state != HALTED;
    assign cyc_inc = stall_o[0] && state != HALTED;

    pipe_ctrl_sat_counter #(.W(CNT_W), .LIMIT(CNT_W'(MAX_STALL))) u_wd (
        .clk(clk), .rst(rst), .inc(wd_inc), .clr(!wd_inc), .q(wd_cnt)
    );

    pipe_ctrl_sat_counter #(.W(32), .LIMIT(32'hFFFF_FFFF)) u_cyc (
        .clk(clk), .rst(rst), .inc(cyc_inc), .clr(1'b0), .q(stall_cycles_o)
    );

    // sticky timeout, raised on the edge where the watchdog count reaches MAX_STALL
    always_ff @(posedge clk)
        stall_timeout_o <= rst ? 1'b0 : stall_timeout_o | (wd_inc && wd_cnt >= CNT_W'(MAX_STALL - 1));
endmodule
